// File: rtl/projectile_grid.sv
// Projectile field: shots enter row 0 of a column and advance one row per divider tick.
// Define PROJECTILE_GRID_WRAP_EN to recirculate the last row into row 0 instead of counting escapes.
module projectile_grid #(
    parameter int COLS           = 160,
    parameter int ROWS           = 120,
    parameter int TICK_DIV       = 3125000,
    parameter int COOLDOWN_TICKS = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 shoot,
    input  logic [7:0]           shoot_x,
    input  logic                 clr_valid,
    input  logic [7:0]           clr_x,
    input  logic [7:0]           clr_y,
    output logic [COLS*ROWS-1:0] grid,
    output logic                 tick,
    output logic                 ready,
    output logic [15:0]          escaped_count,
    output logic [0:0]           fsm_state
);

    localparam logic [0:0]  READY      = 1'b0;
    localparam logic [0:0]  COOLDOWN   = 1'b1;
    localparam logic [27:0] DIV_RELOAD = 28'(TICK_DIV - 1);
    localparam logic [7:0]  CD_RELOAD  = 8'(COOLDOWN_TICKS);

    logic                 restart;
    logic                 tick_now;
    logic                 fire;
    logic [27:0]          div_cnt;
    logic [0:0]           state;
    logic [7:0]           cd_cnt;
    logic                 shoot_prev;
    logic [COLS*ROWS-1:0] clr_mask;
    logic [COLS*ROWS-1:0] cleared;
    logic [COLS*ROWS-1:0] next_grid;

    assign restart   = !reset_n || start;
    assign tick_now  = (div_cnt == 28'd0) && !restart;
    assign tick      = tick_now;
    assign fire      = (state == READY) && shoot && !shoot_prev && (int'(shoot_x) < COLS);
    assign ready     = (state == READY);
    assign fsm_state = state;

    // Clear works on pre-update contents, so a cleared bit never shifts onward.
    // Without a tick it also beats a load into the same cell.
    always_comb begin
        clr_mask = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (clr_valid && int'(clr_x) == c && int'(clr_y) == r)
                    clr_mask[ROWS*c+r] = 1'b1;
            end
        end
        cleared   = grid & ~clr_mask;
        next_grid = cleared;
        if (tick_now) begin
            for (int c = 0; c < COLS; c++) begin
                for (int r = ROWS - 1; r >= 1; r--)
                    next_grid[ROWS*c+r] = cleared[ROWS*c+r-1];
`ifdef PROJECTILE_GRID_WRAP_EN
                next_grid[ROWS*c] = cleared[ROWS*c+ROWS-1];
`else
                next_grid[ROWS*c] = 1'b0;
`endif
            end
        end
        if (fire) begin
            for (int c = 0; c < COLS; c++) begin
                if (int'(shoot_x) == c)
                    next_grid[ROWS*c] = 1'b1;
            end
        end
        if (!tick_now)
            next_grid = next_grid & ~clr_mask;
    end

`ifndef PROJECTILE_GRID_WRAP_EN
    logic [8:0]  esc_add;
    logic [16:0] esc_sum;

    always_comb begin
        esc_add = '0;
        for (int c = 0; c < COLS; c++)
            esc_add = esc_add + 9'(cleared[ROWS*c+ROWS-1]);
        esc_sum = {1'b0, escaped_count} + 17'(esc_add);
    end
`endif

    always_ff @(posedge clock) begin
        if (restart) begin
            grid          <= '0;
            div_cnt       <= DIV_RELOAD;
            state         <= READY;
            cd_cnt        <= '0;
            escaped_count <= '0;
            shoot_prev    <= 1'b1;
        end else begin
            grid       <= next_grid;
            shoot_prev <= shoot;
            div_cnt    <= tick_now ? DIV_RELOAD : div_cnt - 28'd1;
`ifdef PROJECTILE_GRID_WRAP_EN
            escaped_count <= '0;
`else
            if (tick_now)
                escaped_count <= esc_sum[16] ? 16'hffff : esc_sum[15:0];
`endif
            case (state)
                READY: begin
                    if (fire) begin
                        state  <= COOLDOWN;
                        cd_cnt <= CD_RELOAD;
                    end
                end
                COOLDOWN: begin
                    if (cd_cnt == 8'd0)
                        state <= READY;
                    else if (tick_now)
                        cd_cnt <= cd_cnt - 8'd1;
                end
                default: state <= READY;
            endcase
        end
    end

endmodule

// File: tb/tb_projectile_grid.sv
// Directed bench for projectile_grid with COLS=4, ROWS=8, TICK_DIV=4, COOLDOWN_TICKS=2.
module tb_projectile_grid;

    localparam int COLS = 4;
    localparam int ROWS = 8;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic                 shoot = 1'b0;
    logic [7:0]           shoot_x = '0;
    logic                 clr_valid = 1'b0;
    logic [7:0]           clr_x = '0;
    logic [7:0]           clr_y = '0;
    logic [COLS*ROWS-1:0] grid;
    logic                 tick;
    logic                 ready;
    logic [15:0]          escaped_count;
    logic [0:0]           fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    projectile_grid #(
        .COLS(COLS), .ROWS(ROWS), .TICK_DIV(4), .COOLDOWN_TICKS(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .shoot(shoot),
        .shoot_x(shoot_x), .clr_valid(clr_valid), .clr_x(clr_x), .clr_y(clr_y),
        .grid(grid), .tick(tick), .ready(ready), .escaped_count(escaped_count),
        .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Leaves the DUT one cycle past reset with shoot low, divider at 2.
    task automatic do_reset();
        reset_n   = 1'b0;
        shoot     = 1'b0;
        start     = 1'b0;
        clr_valid = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    localparam logic [15:0] ESC_ONE =
`ifdef PROJECTILE_GRID_WRAP_EN
        16'd0;
`else
        16'd1;
`endif
    localparam logic [31:0] GRID_AFTER_ESC =
`ifdef PROJECTILE_GRID_WRAP_EN
        32'h0000_0100;
`else
        32'h0;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        check_eq("rst_grid", 64'(grid), 64'h0);
        check_eq("rst_ready", 64'(ready), 64'h1);
        check_eq("rst_tick", 64'(tick), 64'h0);
        check_eq("rst_esc", 64'(escaped_count), 64'h0);
        check_eq("rst_state", 64'(fsm_state), 64'h0);

        // Single shot in column 2 advancing three rows
        do_reset();
        shoot = 1'b1; shoot_x = 8'd2;
        step(1);
        check_eq("shot_load", 64'(grid), 64'h0001_0000);
        check_eq("shot_ready", 64'(ready), 64'h0);
        shoot = 1'b0;
        step(1);
        check_eq("tick_pulse", 64'(tick), 64'h1);
        step(1);
        check_eq("shift1", 64'(grid), 64'h0002_0000);
        check_eq("cool_ready", 64'(ready), 64'h0);
        step(5);
        check_eq("cool_done", 64'(ready), 64'h1);
        step(3);
        check_eq("shift3", 64'(grid), 64'h0008_0000);

        // Held shoot fires once; a new rise fires again
        do_reset();
        shoot = 1'b1; shoot_x = 8'd1;
        step(20);
        check_eq("held_once", 64'(grid), 64'h0000_2000);
        check_eq("held_ready", 64'(ready), 64'h1);
        shoot = 1'b0;
        step(1);
        shoot = 1'b1;
        step(1);
        check_eq("refire", 64'(grid), 64'h0000_2100);
        check_eq("refire_ready", 64'(ready), 64'h0);
        shoot = 1'b0;

        // Out-of-range column is ignored; COLS-1 is accepted
        do_reset();
        shoot = 1'b1; shoot_x = 8'd7;
        step(1);
        check_eq("oor7_grid", 64'(grid), 64'h0);
        check_eq("oor7_ready", 64'(ready), 64'h1);
        shoot = 1'b0;
        step(1);
        shoot = 1'b1; shoot_x = 8'd4;
        step(1);
        check_eq("oor4_grid", 64'(grid), 64'h0);
        check_eq("oor4_ready", 64'(ready), 64'h1);
        shoot = 1'b0;
        step(1);
        shoot = 1'b1; shoot_x = 8'd3;
        step(1);
        check_eq("col3_load", 64'(grid), 64'h0100_0000);
        shoot = 1'b0;

        // Projectile reaches the last row and leaves (or wraps)
        do_reset();
        shoot = 1'b1; shoot_x = 8'd1;
        step(1);
        shoot = 1'b0;
        step(26);
        check_eq("last_row", 64'(grid), 64'h0000_8000);
        check_eq("last_row_esc", 64'(escaped_count), 64'h0);
        step(3);
        check_eq("esc_tick", 64'(tick), 64'h1);
        step(1);
        check_eq("esc_grid", 64'(grid), 64'(GRID_AFTER_ESC));
        check_eq("esc_count", 64'(escaped_count), 64'(ESC_ONE));

        // Clear during a tick stops propagation; out-of-range clears ignored
        do_reset();
        shoot = 1'b1; shoot_x = 8'd2;
        step(1);
        shoot = 1'b0;
        step(10);
        check_eq("pre_clr", 64'(grid), 64'h0008_0000);
        step(3);
        clr_valid = 1'b1; clr_x = 8'd2; clr_y = 8'd3;
        step(1);
        clr_valid = 1'b0;
        check_eq("clr_tick_bit20", 64'(grid[20]), 64'h0);
        check_eq("clr_tick_grid", 64'(grid), 64'h0);
        check_eq("clr_tick_esc", 64'(escaped_count), 64'h0);
        shoot = 1'b1; shoot_x = 8'd0;
        step(1);
        shoot = 1'b0;
        check_eq("col0_load", 64'(grid), 64'h1);
        clr_valid = 1'b1; clr_x = 8'd4; clr_y = 8'd0;
        step(1);
        check_eq("clr_oor_x", 64'(grid), 64'h1);
        clr_x = 8'd0; clr_y = 8'd8;
        step(1);
        check_eq("clr_oor_y", 64'(grid), 64'h1);
        clr_valid = 1'b0;
        step(1);
        check_eq("col0_shift", 64'(grid), 64'h2);
        clr_valid = 1'b1; clr_x = 8'd0; clr_y = 8'd1;
        step(1);
        clr_valid = 1'b0;
        check_eq("clr_plain", 64'(grid), 64'h0);

        // Start mid-cooldown, coincident with a tick, with shoot held
        do_reset();
        shoot = 1'b1; shoot_x = 8'd3;
        step(1);
        check_eq("pre_start", 64'(grid), 64'h0100_0000);
        step(1);
        start = 1'b1;
        step(1);
        check_eq("start_grid", 64'(grid), 64'h0);
        check_eq("start_ready", 64'(ready), 64'h1);
        check_eq("start_tick", 64'(tick), 64'h0);
        start = 1'b0;
        step(1);
        check_eq("start_nofire", 64'(grid), 64'h0);
        check_eq("start_ready2", 64'(ready), 64'h1);
        shoot = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/projectile_grid.md
PROJECTILE_GRID -- requirements
Module: projectile_grid

Interface
REQ-001 Parameter COLS, default 160, number of grid columns (x positions), range 1..255.
REQ-002 Parameter ROWS, default 120, number of grid rows (y positions), range 2..255.
REQ-003 Parameter TICK_DIV, default 3125000, clocks per shift tick, range 1..2^28-1.
REQ-004 Parameter COOLDOWN_TICKS, default 4, shift ticks blocked after a shot, range 0..255.
REQ-005 clock  input  1  system clock, all state on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 start  input  1  synchronous active-high game restart; same effect as reset.
REQ-008 shoot  input  1  fire request; level, rising-edge detected internally.
REQ-009 shoot_x  input  8  column for new projectile.
REQ-010 clr_valid  input  1  one-cycle request to erase one cell (collision).
REQ-011 clr_x  input  8  column of cell to erase.
REQ-012 clr_y  input  8  row of cell to erase.
REQ-013 grid  output  COLS*ROWS  occupancy; cell (c,r) at bit ROWS*c+r.
REQ-014 tick  output  1  one-cycle pulse on each shift.
REQ-015 ready  output  1  high when fire FSM in READY.
REQ-016 escaped_count  output  16  projectiles shifted out past row ROWS-1, saturating.

Function
REQ-017 Divider shall count down TICK_DIV-1..0; tick asserted in the cycle the count is 0, then reload TICK_DIV-1.
REQ-018 On tick, every column shall shift: cell (c,r) <= (c,r-1) for r>=1; row 0 receives 0 unless loaded (REQ-021).
REQ-019 Shoot edge = shoot high this cycle and low previous cycle; held-high shoot shall fire once only.
REQ-020 Fire FSM states READY, COOLDOWN; reset state READY.
REQ-021 READY + shoot edge + shoot_x<COLS: set cell (shoot_x,0) at end of cycle; go COOLDOWN with cooldown counter = COOLDOWN_TICKS.
REQ-022 READY + shoot edge + shoot_x>=COLS: ignored, no load, stay READY.
REQ-023 COOLDOWN: shoot edges ignored; counter decrements on each tick; at 0 (or if COOLDOWN_TICKS=0) return READY next cycle.
REQ-024 Same-cycle priority per cell: clear > load > shift.
REQ-025 Clear addresses pre-update contents; cleared bit shall not propagate on a coincident tick; out-of-range clr_x/clr_y ignored.
REQ-026 Load coincident with tick: shifted array computed first, then row 0 of shoot_x set to 1.
REQ-027 escaped_count shall add number of set bits in row ROWS-1 on each tick (after clear), saturating at 65535.
REQ-028 grid is a registered output; load/clear/shift visible one cycle after the triggering edge.

Reset
REQ-029 reset_n low or start high: grid=0, divider=TICK_DIV-1, tick=0, FSM=READY, ready=1, cooldown=0, escaped_count=0, edge history=1 (no fire on first cycle after reset).
REQ-030 Reset/start shall override all same-cycle shoot, clear and tick activity, including mid-cooldown.

Configuration
REQ-031 Macro PROJECTILE_GRID_WRAP_EN defined: on tick, row ROWS-1 feeds row 0 of the same column (OR with load); escaped_count held at 0.
REQ-032 PROJECTILE_GRID_WRAP_EN undefined: row ROWS-1 bits discarded and counted per REQ-027.

Verification (COLS=4, ROWS=8, TICK_DIV=4, COOLDOWN_TICKS=2)
REQ-033 Reset, shoot rise with shoot_x=2 -> bit 16 set next cycle, ready=0; after 3 ticks bit 19 set only.
REQ-034 Shoot held high 20 cycles -> exactly one projectile; second rise after 2 ticks fires again.
REQ-035 shoot_x=7 -> grid unchanged, ready stays 1.
REQ-036 Projectile at (1,7), tick -> grid bit cleared, escaped_count=1 (wrap off); with wrap on -> bit 8 set, count 0.
REQ-037 clr_valid at (2,3) in tick cycle with bit (2,3) set -> bit (2,4) not set; start asserted mid-cooldown -> grid 0, ready=1 next cycle.
